col_skew_feeder: RTL

Read-side counterpart of the three column input FIFOs in the 3x3 systolic array top. On a start command it drains a programmed number of words from all three FIFOs in lock-step and presents them to the array's column inputs. Lane k is skewed by k-1 cycles, which gives the diagonal wavefront the processing elements need. It replaces direct FIFO-to-array wiring and adds start/busy/done sequencing for the array controller.

---
 rtl/col_skew_feeder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/col_skew_feeder.sv
// Drains three column FIFOs in lock-step and presents the words to the systolic array.
// Lane k is delayed by k-1 cycles so that the data arrives as a diagonal wavefront.
module col_skew_feeder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  array_ready,
    input  logic                  empty1,
    input  logic                  empty2,
    input  logic                  empty3,
    output logic                  rd_en1,
    output logic                  rd_en2,
    output logic                  rd_en3,
    input  logic [DATA_WIDTH-1:0] dout1,
    input  logic [DATA_WIDTH-1:0] dout2,
    input  logic [DATA_WIDTH-1:0] dout3,
    output logic [DATA_WIDTH-1:0] col_out1,
    output logic [DATA_WIDTH-1:0] col_out2,
    output logic [DATA_WIDTH-1:0] col_out3,
    output logic                  col_valid1,
    output logic                  col_valid2,
    output logic                  col_valid3,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FCNT_W = 2;
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [FCNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                  rd_go_c;

    logic                  rd_flag_q;
    logic                  s0_v_q;
    logic [DATA_WIDTH-1:0] s0_d1_q, s0_d2_q, s0_d3_q;
    logic                  l2_v_q;
    logic [DATA_WIDTH-1:0] l2_d_q;
    logic                  l3a_v_q, l3b_v_q;
    logic [DATA_WIDTH-1:0] l3a_d_q, l3b_d_q;

    // All-or-nothing read: every lane must have data and the array must accept it.
    assign rd_go_c = (state_q == RUN) && (remaining_q != '0) && !empty1 && !empty2
                     && !empty3 && array_ready;

    // State register and control counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic; a zero-length start jumps straight to the final flush cycle.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        remaining_d = len;
                        state_d     = RUN;
                    end else begin
                        flush_cnt_d = FLUSH_LAST;
                        state_d     = FLUSH;
                    end
                end
            end
            RUN: begin
                if (rd_go_c) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control outputs decoded from state
    always_comb begin
        rd_en1 = rd_go_c;
        rd_en2 = rd_go_c;
        rd_en3 = rd_go_c;
        busy   = (state_q != IDLE);
        done   = (state_q == FLUSH) && (flush_cnt_q == FLUSH_LAST);
    end

    // Skew pipeline shifts every cycle; bubbles travel as valid=0 with zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_flag_q <= 1'b0;
            s0_v_q    <= 1'b0;
            s0_d1_q   <= '0;
            s0_d2_q   <= '0;
            s0_d3_q   <= '0;
            l2_v_q    <= 1'b0;
            l2_d_q    <= '0;
            l3a_v_q   <= 1'b0;
            l3a_d_q   <= '0;
            l3b_v_q   <= 1'b0;
            l3b_d_q   <= '0;
        end else begin
            rd_flag_q <= rd_go_c;
            s0_v_q    <= rd_flag_q;
            s0_d1_q   <= rd_flag_q ? dout1 : '0;
            s0_d2_q   <= rd_flag_q ? dout2 : '0;
            s0_d3_q   <= rd_flag_q ? dout3 : '0;
            l2_v_q    <= s0_v_q;
            l2_d_q    <= s0_d2_q;
            l3a_v_q   <= s0_v_q;
            l3a_d_q   <= s0_d3_q;
            l3b_v_q   <= l3a_v_q;
            l3b_d_q   <= l3a_d_q;
        end
    end

    assign col_out1   = s0_d1_q;
    assign col_valid1 = s0_v_q;
    assign col_out2   = l2_d_q;
    assign col_valid2 = l2_v_q;
    assign col_out3   = l3b_d_q;
    assign col_valid3 = l3b_v_q;

endmodule
